// File: rtl/scoreboard_multi.sv
// scoreboard_multi: N-player debounced BCD scoreboard, first-to-WIN game FSM, muxed 7-seg driver.
// Optional undo button is compiled in when SCOREBOARD_UNDO_EN is defined.
module scoreboard_multi #(
    parameter int NUM_PLAYERS     = 2,
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int WIN_SCORE       = 21,
    parameter int SCAN_CYCLES     = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_PLAYERS-1:0]   btn_i,
    input  logic                     clear_i,
    input  logic                     undo_i,
    output logic [6:0]               seg_o,
    output logic [2*NUM_PLAYERS-1:0] digit_sel_o,
    output logic [8*NUM_PLAYERS-1:0] score_o,
    output logic [NUM_PLAYERS-1:0]   winner_o,
    output logic                     game_over_o
);
`ifdef SCOREBOARD_UNDO_EN
    localparam int NB = NUM_PLAYERS + 1;
`else
    localparam int NB = NUM_PLAYERS;
`endif
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam int NS = 2 * NUM_PLAYERS;
    localparam int SW = $clog2(NS);
    localparam int KW = SCAN_CYCLES > 1 ? $clog2(SCAN_CYCLES) : 1;
    localparam int LW = $clog2(NUM_PLAYERS);
    localparam logic [7:0] WIN_BCD = 8'((WIN_SCORE / 10) * 16 + WIN_SCORE % 10);

    typedef enum logic {PLAY, OVER} state_t;

    logic [NB-1:0]                 raw, sync1, sync2, stable, press;
    logic [NB-1:0][CW-1:0]         cnt;
    state_t                        state, state_nxt;
    logic [NUM_PLAYERS-1:0][7:0]   score, score_nxt;
    logic [NUM_PLAYERS-1:0]        winner_nxt;
    logic [SW-1:0]                 slot;
    logic [KW-1:0]                 hold;
    logic [8:0]                    blink;
    logic [3:0]                    digit;
    logic [6:0]                    seg_nxt;
    logic                          blank;
    logic                          any_press;

`ifdef SCOREBOARD_UNDO_EN
    logic [LW-1:0] last, last_nxt;
    logic          valid, valid_nxt;
    assign raw = {undo_i, btn_i};
`else
    logic unused_undo;
    assign unused_undo = undo_i;
    assign raw = btn_i;
`endif

    assign score_o   = score;
    assign any_press = |press[NUM_PLAYERS-1:0];

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v == 8'h99) return v;
        return (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        return (v[3:0] == 4'd0) ? {v[7:4] - 4'd1, 4'd9} : {v[7:4], v[3:0] - 4'd1};
    endfunction

    function automatic logic [6:0] seg_lut(input logic [3:0] d);
        case (d)
            4'd0: return 7'b0111111;
            4'd1: return 7'b0000110;
            4'd2: return 7'b1011011;
            4'd3: return 7'b1001111;
            4'd4: return 7'b1100110;
            4'd5: return 7'b1101101;
            4'd6: return 7'b1111101;
            4'd7: return 7'b0000111;
            4'd8: return 7'b1111111;
            4'd9: return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    // Synchronise each button, accept a level after DEBOUNCE_CYCLES stable cycles, pulse on accepted rise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= '0;
            sync2  <= '0;
            stable <= '0;
            press  <= '0;
            cnt    <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int i = 0; i < NB; i++) begin
                press[i] <= 1'b0;
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    cnt[i]    <= '0;
                    stable[i] <= sync2[i];
                    press[i]  <= sync2[i];
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Game state register: FSM state, scores, winner and undo bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= PLAY;
            score    <= '0;
            winner_o <= '0;
`ifdef SCOREBOARD_UNDO_EN
            last     <= '0;
            valid    <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            score    <= score_nxt;
            winner_o <= winner_nxt;
`ifdef SCOREBOARD_UNDO_EN
            last     <= last_nxt;
            valid    <= valid_nxt;
`endif
        end
    end

    // Next state: clear beats presses, presses beat undo; descending scan leaves the lowest index as winner
    always_comb begin
        state_nxt  = state;
        score_nxt  = score;
        winner_nxt = winner_o;
`ifdef SCOREBOARD_UNDO_EN
        last_nxt   = last;
        valid_nxt  = valid;
`endif
        if (clear_i) begin
            state_nxt  = PLAY;
            score_nxt  = '0;
            winner_nxt = '0;
`ifdef SCOREBOARD_UNDO_EN
            valid_nxt  = 1'b0;
`endif
        end else if (state == PLAY && any_press) begin
            for (int p = NUM_PLAYERS - 1; p >= 0; p--) begin
                if (press[p]) begin
                    score_nxt[p] = bcd_inc(score[p]);
`ifdef SCOREBOARD_UNDO_EN
                    last_nxt     = LW'(p);
                    valid_nxt    = 1'b1;
`endif
                    if (bcd_inc(score[p]) == WIN_BCD) begin
                        state_nxt     = OVER;
                        winner_nxt    = '0;
                        winner_nxt[p] = 1'b1;
                    end
                end
            end
        end
`ifdef SCOREBOARD_UNDO_EN
        else if (press[NUM_PLAYERS] && valid && score[last] != 8'h00) begin
            score_nxt[last] = bcd_dec(score[last]);
            valid_nxt       = 1'b0;
            state_nxt       = PLAY;
            winner_nxt      = '0;
        end
`endif
    end

    // Game-over flag follows the FSM state directly
    always_comb game_over_o = (state == OVER);

    // Select the digit for the current slot; blank leading tens zero and the blinking winner
    always_comb begin
        digit   = slot[0] ? score[slot[SW-1:1]][7:4] : score[slot[SW-1:1]][3:0];
        blank   = (slot[0] && digit == 4'd0) || (state == OVER && winner_o[slot[SW-1:1]] && blink[8]);
        seg_nxt = blank ? 7'b0000000 : seg_lut(digit);
    end

    // Register segment bus and digit enable together, then step the scan slot every SCAN_CYCLES
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot        <= '0;
            hold        <= '0;
            blink       <= '0;
            seg_o       <= '0;
            digit_sel_o <= '0;
        end else begin
            seg_o       <= seg_nxt;
            digit_sel_o <= NS'(1) << slot;
            blink       <= blink + 1'b1;
            if (hold == KW'(SCAN_CYCLES - 1)) begin
                hold <= '0;
                slot <= (slot == SW'(NS - 1)) ? '0 : slot + 1'b1;
            end else begin
                hold <= hold + 1'b1;
            end
        end
    end
endmodule
